// File: rtl/array_host_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_host_driver : weight preload / start / result sequencer for the systolic
// matrix-vector array. Option macro: ARRAY_HOST_DRIVER_REUSE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module array_host_driver #(
  parameter int DW      = 8,
  parameter int ROWS    = 2,
  parameter int COLS    = 2,
  parameter int ROW_W   = 1,
  parameter int COL_W   = 1,
  parameter int ACC_W   = 16,
  parameter int CYCLE_W = 3,
  parameter int LAT     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [COLS*DW-1:0]       x_data,
  output logic                     preload_valid,
  output logic [ROW_W+COL_W-1:0]   preload_addr,
  output logic [DW-1:0]            preload_data,
  output logic                     start,
  output logic [COLS*DW-1:0]       x_vector_flat,
  input  logic [ROWS*ACC_W-1:0]    result_flat,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [ACC_W-1:0]         r_data,
  output logic                     r_last,
`ifdef ARRAY_HOST_DRIVER_REUSE_EN
  input  logic                     reload,
`endif
  output logic                     busy
);

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    WAIT_X = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

`ifdef ARRAY_HOST_DRIVER_REUSE_EN
  localparam state_t DRAIN_NEXT = WAIT_X;
  logic reload_req;
  assign reload_req = reload;
`else
  localparam state_t DRAIN_NEXT = LOAD;
  logic reload_req;
  assign reload_req = 1'b0;
`endif

  state_t                  state, state_nx;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [CYCLE_W-1:0]      cnt;
  logic [ROW_W-1:0]        idx;
  logic [ROWS*ACC_W-1:0]   res;

  logic s_hs, x_hs, r_hs, last_beat, run_done, last_row;

  assign s_ready   = (state == LOAD);
  assign x_ready   = (state == WAIT_X) && !reload_req;
  assign r_valid   = (state == DRAIN);
  assign busy      = (state == START) || (state == RUN);

  assign s_hs      = s_valid && s_ready;
  assign x_hs      = x_valid && x_ready;
  assign r_hs      = r_valid && r_ready;
  assign last_beat = (row == ROW_W'(ROWS-1)) && (col == COL_W'(COLS-1));
  assign run_done  = (cnt == CYCLE_W'(LAT-1));
  assign last_row  = (idx == ROW_W'(ROWS-1));

  // Captured rows are held, so r_data/r_last stay stable under backpressure.
  assign r_data    = res[int'(idx)*ACC_W +: ACC_W];
  assign r_last    = r_valid && last_row;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (s_hs && last_beat) state_nx = WAIT_X;
      WAIT_X: begin
        if (reload_req) state_nx = LOAD;
        else if (x_hs)  state_nx = START;
      end
      START:   state_nx = RUN;
      RUN:     if (run_done) state_nx = DRAIN;
      DRAIN:   if (r_hs && last_row) state_nx = DRAIN_NEXT;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      preload_valid <= 1'b0;
      preload_addr  <= '0;
      preload_data  <= '0;
      start         <= 1'b0;
      x_vector_flat <= '0;
      row           <= '0;
      col           <= '0;
      cnt           <= '0;
      idx           <= '0;
      res           <= '0;
    end else begin
      preload_valid <= s_hs;
      start         <= x_hs;
      if (s_hs) begin
        preload_addr <= {row, col};
        preload_data <= s_data;
        if (last_beat) begin
          row <= '0;
          col <= '0;
        end else if (col == COL_W'(COLS-1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (x_hs) x_vector_flat <= x_data;
      if (state == START)    cnt <= '0;
      else if (state == RUN) cnt <= cnt + CYCLE_W'(1);
      if ((state == RUN) && run_done) res <= result_flat;
      if (r_hs) idx <= last_row ? '0 : idx + ROW_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_array_host_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_array_host_driver : directed table-driven bench for array_host_driver.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_array_host_driver;

  localparam int DW = 8, ROWS = 2, COLS = 2, ROW_W = 1, COL_W = 1;
  localparam int ACC_W = 16, CYCLE_W = 3, LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, x_valid = 1'b0, r_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [COLS*DW-1:0] x_data = '0;
  logic s_ready, x_ready, preload_valid, start, r_valid, r_last, busy;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0] preload_data;
  logic [COLS*DW-1:0] x_vector_flat;
  logic [ROWS*ACC_W-1:0] result_flat;
  logic [ACC_W-1:0] r_data;
`ifdef ARRAY_HOST_DRIVER_REUSE_EN
  logic reload = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mcnt     = 0;

  always #5 clk = ~clk;

  array_host_driver #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .ACC_W(ACC_W), .CYCLE_W(CYCLE_W), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .preload_valid(preload_valid), .preload_addr(preload_addr),
    .preload_data(preload_data), .start(start), .x_vector_flat(x_vector_flat),
    .result_flat(result_flat), .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_last(r_last),
`ifdef ARRAY_HOST_DRIVER_REUSE_EN
    .reload(reload),
`endif
    .busy(busy)
  );

  // Model array: results are only valid during cycle T+LAT after a start pulse.
  always @(posedge clk) begin
    if (start)              mcnt <= 1;
    else if (mcnt == LAT)   mcnt <= 0;
    else if (mcnt != 0)     mcnt <= mcnt + 1;
  end
  assign result_flat = (mcnt == LAT) ? {16'd39, 16'd17} : {16'hBAD1, 16'hBAD0};

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          epv;
    logic [1:0]    eaddr;
    logic [DW-1:0] edata;
    logic          esr;
  } vec_t;
  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    s_valid = tbl[i].sv;
    s_data  = tbl[i].sd;
    step();
    chk($sformatf("v%0d preload_valid", i), 32'(preload_valid), 32'(tbl[i].epv));
    if (tbl[i].epv) begin
      chk($sformatf("v%0d preload_addr", i), 32'(preload_addr), 32'(tbl[i].eaddr));
      chk($sformatf("v%0d preload_data", i), 32'(preload_data), 32'(tbl[i].edata));
    end
    chk($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(tbl[i].esr));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'd1,   1'b1, 2'd0, 8'd1,   1'b1};
    tbl[1]  = '{1'b1, 8'd2,   1'b1, 2'd1, 8'd2,   1'b1};
    tbl[2]  = '{1'b1, 8'd3,   1'b1, 2'd2, 8'd3,   1'b1};
    tbl[3]  = '{1'b1, 8'd4,   1'b1, 2'd3, 8'd4,   1'b0};
    tbl[4]  = '{1'b1, 8'h10,  1'b1, 2'd0, 8'h10,  1'b1};
    tbl[5]  = '{1'b0, 8'hEE,  1'b0, 2'd0, 8'h00,  1'b1};
    tbl[6]  = '{1'b1, 8'hF0,  1'b1, 2'd1, 8'hF0,  1'b1};
    tbl[7]  = '{1'b0, 8'hEE,  1'b0, 2'd0, 8'h00,  1'b1};
    tbl[8]  = '{1'b1, 8'h7F,  1'b1, 2'd2, 8'h7F,  1'b1};
    tbl[9]  = '{1'b0, 8'hEE,  1'b0, 2'd0, 8'h00,  1'b1};
    tbl[10] = '{1'b1, 8'h80,  1'b1, 2'd3, 8'h80,  1'b0};

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst preload_valid", 32'(preload_valid), 32'd0);
    chk("rst preload_addr",  32'(preload_addr),  32'd0);
    chk("rst preload_data",  32'(preload_data),  32'd0);
    chk("rst start",         32'(start),         32'd0);
    chk("rst x_vector_flat", 32'(x_vector_flat), 32'd0);
    chk("rst r_valid",       32'(r_valid),       32'd0);
    chk("rst r_last",        32'(r_last),        32'd0);
    chk("rst r_data",        32'(r_data),        32'd0);
    chk("rst busy",          32'(busy),          32'd0);
    chk("rst s_ready",       32'(s_ready),       32'd1);
    chk("rst x_ready",       32'(x_ready),       32'd0);
    rst = 1'b0;

    // Back-to-back weight load
    for (int i = 0; i < 4; i++) apply_vec(i);
    s_valid = 1'b0;

    // Activation vector and run
    chk("wait x_ready", 32'(x_ready), 32'd1);
    x_valid = 1'b1;
    x_data  = {8'd6, 8'd5};
    step();
    x_valid = 1'b0;
    chk("T start",         32'(start),         32'd1);
    chk("T x_vector_flat", 32'(x_vector_flat), 32'h0605);
    chk("T busy",          32'(busy),          32'd1);
    chk("T x_ready",       32'(x_ready),       32'd0);
    chk("T preload_valid", 32'(preload_valid), 32'd0);
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      chk($sformatf("T+%0d start", k),   32'(start),   32'd0);
      chk($sformatf("T+%0d r_valid", k), 32'(r_valid), 32'(k == LAT + 1));
      chk($sformatf("T+%0d busy", k),    32'(busy),    32'(k != LAT + 1));
    end
    chk("drain r_data0", 32'(r_data), 32'd17);
    chk("drain r_last0", 32'(r_last), 32'd0);

    // Backpressure in DRAIN; other streams ignored
    s_valid = 1'b1;
    x_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d r_valid", k), 32'(r_valid), 32'd1);
      chk($sformatf("stall%0d r_data", k),  32'(r_data),  32'd17);
      chk($sformatf("stall%0d r_last", k),  32'(r_last),  32'd0);
      chk($sformatf("stall%0d preload", k), 32'(preload_valid), 32'd0);
      chk($sformatf("stall%0d s_ready", k), 32'(s_ready), 32'd0);
      chk($sformatf("stall%0d x_ready", k), 32'(x_ready), 32'd0);
    end
    s_valid = 1'b0;
    x_valid = 1'b0;
    r_ready = 1'b1;
    step();
    chk("drain r_data1", 32'(r_data), 32'd39);
    chk("drain r_last1", 32'(r_last), 32'd1);
    chk("drain r_valid1", 32'(r_valid), 32'd1);
    step();
    r_ready = 1'b0;
    chk("post r_valid", 32'(r_valid), 32'd0);
`ifdef ARRAY_HOST_DRIVER_REUSE_EN
    chk("reuse x_ready", 32'(x_ready), 32'd1);
    reload = 1'b1;
    #1;
    chk("reload x_ready", 32'(x_ready), 32'd0);
    step();
    reload = 1'b0;
`endif
    chk("post s_ready", 32'(s_ready), 32'd1);

    // Gapped weight load, signed extremes
    for (int i = 4; i < 11; i++) apply_vec(i);
    s_valid = 1'b0;

    // Reset during RUN
    x_valid = 1'b1;
    x_data  = {8'hFA, 8'h80};
    step();
    x_valid = 1'b0;
    chk("T2 x_vector_flat", 32'(x_vector_flat), 32'hFA80);
    step(); step(); step();
    chk("run busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy",    32'(busy),    32'd0);
    chk("midrst r_valid", 32'(r_valid), 32'd0);
    chk("midrst s_ready", 32'(s_ready), 32'd1);
    chk("midrst start",   32'(start),   32'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      chk($sformatf("idle%0d r_valid", k), 32'(r_valid), 32'd0);
      chk($sformatf("idle%0d start", k),   32'(start),   32'd0);
    end
    s_valid = 1'b1;
    s_data  = 8'd9;
    step();
    s_valid = 1'b0;
    chk("fresh preload_valid", 32'(preload_valid), 32'd1);
    chk("fresh preload_addr",  32'(preload_addr),  32'd0);
    chk("fresh preload_data",  32'(preload_data),  32'd9);
    step();
    chk("fresh gap preload_valid", 32'(preload_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
